// File: rtl/ir_move_transmitter.sv
// SIRC-style IR move-command transmitter: start burst + 12 bits LSB first.
// Define IR_CARRIER_EN to modulate ir_out with the internal carrier.
module ir_move_transmitter #(
  parameter int unsigned UNIT_CYCLES  = 16200,
  parameter int unsigned CARRIER_HALF = 337,
  parameter int unsigned FRAME_CYCLES = 1215000,
  parameter int unsigned REPEAT_COUNT = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        transmit,
  input  logic [11:0] move_command,
  output logic        ir_out,
  output logic        busy,
  output logic        done,
  output logic [3:0]  frames_sent
);

  localparam int unsigned FW = $clog2(FRAME_CYCLES);
  localparam int unsigned PW = $clog2(4 * UNIT_CYCLES + 1);

  localparam logic [PW-1:0] START_LAST = PW'(4 * UNIT_CYCLES - 1);
  localparam logic [PW-1:0] ONE_LAST   = PW'(UNIT_CYCLES - 1);
  localparam logic [PW-1:0] TWO_LAST   = PW'(2 * UNIT_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [4:0]    REPEAT_LIM = 5'(REPEAT_COUNT);

  generate
    if (REPEAT_COUNT < 1 || REPEAT_COUNT > 15 ||
        FRAME_CYCLES < 41 * UNIT_CYCLES ||
        UNIT_CYCLES < 1 || CARRIER_HALF < 1) begin : g_bad_params
      $error("ir_move_transmitter: illegal parameters");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    SPACE,
    MARK,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic [11:0]   cmd_q, cmd_d;
  logic [3:0]    frames_d;
  logic [PW-1:0] mark_last;
  logic          env_d, busy_d, done_d, ir_d;

  assign mark_last = cmd_q[idx_q] ? TWO_LAST : ONE_LAST;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + 1'b1;
    frame_d  = frame_q + 1'b1;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    frames_d = frames_sent;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        frame_d = '0;
        if (transmit) begin
          state_d  = START;
          cmd_d    = move_command;
          frames_d = '0;
          idx_d    = '0;
        end
      end
      START: begin
        if (phase_q == START_LAST) begin
          state_d = SPACE;
          phase_d = '0;
        end
      end
      SPACE: begin
        if (phase_q == ONE_LAST) begin
          state_d = MARK;
          phase_d = '0;
        end
      end
      MARK: begin
        if (phase_q == mark_last) begin
          phase_d = '0;
          if (idx_q == 4'd11) begin
            state_d = GAP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SPACE;
          end
        end
      end
      GAP: begin
        phase_d = '0;
        if (frame_q == FRAME_LAST) begin
          frame_d  = '0;
          idx_d    = '0;
          frames_d = frames_sent + 1'b1;
          if ({1'b0, frames_sent} + 5'd1 < REPEAT_LIM) begin
            state_d = START;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so they line up with the registered state.
  assign env_d  = (state_d == START) || (state_d == MARK);
  assign busy_d = (state_d != IDLE);

`ifdef IR_CARRIER_EN
  localparam int unsigned CW = $clog2(CARRIER_HALF + 1);
  localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] car_cnt_q, car_cnt_d;
  logic          car_q, car_d, env_q;

  // Reload on each envelope rise so every mark starts with carrier high.
  always_comb begin
    car_cnt_d = '0;
    car_d     = 1'b0;
    if (env_d && !env_q) begin
      car_d = 1'b1;
    end else if (env_d) begin
      if (car_cnt_q == CAR_LAST) begin
        car_d = ~car_q;
      end else begin
        car_cnt_d = car_cnt_q + 1'b1;
        car_d     = car_q;
      end
    end
  end

  assign ir_d = env_d & car_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      car_cnt_q <= '0;
      car_q     <= 1'b0;
      env_q     <= 1'b0;
    end else begin
      car_cnt_q <= car_cnt_d;
      car_q     <= car_d;
      env_q     <= env_d;
    end
  end
`else
  assign ir_d = env_d;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      frame_q     <= '0;
      idx_q       <= '0;
      cmd_q       <= '0;
      frames_sent <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ir_out      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      frames_sent <= frames_d;
      busy        <= busy_d;
      done        <= done_d;
      ir_out      <= ir_d;
    end
  end

endmodule

// File: tb/tb_ir_move_transmitter.sv
// Scoreboard bench for ir_move_transmitter (U=4, CH=1, F=200, R=2).
// Expected ir_out/busy/done per cycle are queued when a request is driven.
module tb_ir_move_transmitter;

  logic        clock;
  logic        reset_n;
  logic        transmit;
  logic [11:0] move_command;
  logic        ir_out;
  logic        busy;
  logic        done;
  logic [3:0]  frames_sent;

  ir_move_transmitter #(
    .UNIT_CYCLES (4),
    .CARRIER_HALF(1),
    .FRAME_CYCLES(200),
    .REPEAT_COUNT(2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .transmit    (transmit),
    .move_command(move_command),
    .ir_out      (ir_out),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic ir;
    logic bsy;
    logic dn;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ir_hi = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic mark_val(input int o);
`ifdef IR_CARRIER_EN
    return (o % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_ir(input logic [11:0] w, input int fc);
    int pos;
    int len;
    if (fc < 16) return mark_val(fc);
    pos = 16;
    for (int i = 0; i < 12; i++) begin
      pos += 4;
      len = w[i] ? 8 : 4;
      if (fc >= pos && fc < pos + len) return mark_val(fc - pos);
      pos += len;
    end
    return 1'b0;
  endfunction

  function automatic int frame_hi(input logic [11:0] w);
    int s;
    s = 16;
    for (int i = 0; i < 12; i++) s += w[i] ? 8 : 4;
`ifdef IR_CARRIER_EN
    return s / 2;
`else
    return s;
`endif
  endfunction

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (ir_out) ir_hi++;
    if (done) done_cnt++;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ir_out", ir_out, e.ir);
      chk("busy", busy, e.bsy);
      chk("done", done, e.dn);
    end
  end

  // Called at a negedge; queues the first n cycles of the request.
  task automatic send(input logic [11:0] w, input int n);
    exp_t e;
    ir_hi    = 0;
    done_cnt = 0;
    transmit     = 1'b1;
    move_command = w;
    for (int j = 0; j < n; j++) begin
      if (j < 400) begin
        e.ir  = exp_ir(w, j % 200);
        e.bsy = 1'b1;
        e.dn  = 1'b0;
      end else begin
        e = '{ir: 1'b0, bsy: 1'b0, dn: 1'b1};
      end
      q.push_back(e);
    end
    @(negedge clock);
    transmit = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 1000 && q.size() != 0; c++) @(negedge clock);
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic finish_req(input logic [11:0] w);
    drain();
    chk("hi_count", ir_hi, 2 * frame_hi(w));
    chk("done_cnt", done_cnt, 1);
    chk("frames_sent", frames_sent, 2);
  endtask

  initial begin
    reset_n      = 1'b0;
    transmit     = 1'b0;
    move_command = '0;
    repeat (3) @(negedge clock);
    chk("rst_ir", ir_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    reset_n  = 1'b1;
    ir_hi    = 0;
    done_cnt = 0;
    repeat (100) @(negedge clock);
    chk("idle_ir", ir_hi, 0);
    chk("idle_done", done_cnt, 0);
    chk("idle_busy", busy, 0);
    chk("idle_frames", frames_sent, 0);

    send(12'h00A, 401);
    finish_req(12'h00A);
    send(12'hFFF, 401);
    finish_req(12'hFFF);
    send(12'h000, 401);
    finish_req(12'h000);

    send(12'h5C3, 401);
    repeat (49) @(negedge clock);
    transmit     = 1'b1;
    move_command = 12'h3A5;
    @(negedge clock);
    transmit = 1'b0;
    finish_req(12'h5C3);

    send(12'h00A, 30);
    drain();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ir", ir_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_frames", frames_sent, 0);
    done_cnt = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle", busy, 0);

    send(12'h5A3, 401);
    finish_req(12'h5A3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
